// File: rtl/seg7_pkg.sv
// Shared types, segment lookup table and error codes for the 7-segment capture path.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // hex -> segments, bit0=a .. bit6=g; index is the nibble value
  localparam seg7_t SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [1:0] ERR_BAD_PAT = 2'b01;
  localparam logic [1:0] ERR_BAD_EN  = 2'b10;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

endpackage

// File: rtl/seg7_pattern_encoder.sv
// Combinational reverse lookup: segment pattern -> hex nibble, with a hit flag
// for patterns that appear in the table.
module seg7_pattern_encoder
  import seg7_pkg::*;
(
  input  seg7_t      seg,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG7_LUT[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture_encoder.sv
// Display bus monitor: waits for a stable {digit enable, segments} sample,
// then decodes it into the per-digit nibble registers and flags bad patterns/enables.
module seg7_capture_encoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_en_i,
  input  logic                    clr_err_i,
  output logic [4*NUM_DIGITS-1:0] nib_o,
  output logic [NUM_DIGITS-1:0]   dig_valid_o,
  output logic                    upd_o,
  output logic [2:0]              upd_idx_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SMP_W = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t                  state_q;
  logic [SMP_W-1:0]        s_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [SMP_W-1:0]        smp_c;
  logic [NUM_DIGITS-1:0]   en_c;
  logic                    onehot_c;
  logic [2:0]              idx_c;
  logic                    hit_c;
  logic [3:0]              code_c;
  logic                    commit_c;
  logic                    err_new_c;
  logic [1:0]              err_kind_c;

  assign smp_c    = {dig_en_i, seg_i};
  assign en_c     = s_q[SMP_W-1:7];
  assign onehot_c = $onehot(en_c);

  // At commit the input equals s_q, so the registered sample is decoded
  seg7_pattern_encoder u_enc (
    .seg    (s_q[6:0]),
    .hit    (hit_c),
    .nibble (code_c)
  );

  always_comb begin
    idx_c = 3'd0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (en_c[d]) idx_c = 3'(d);
    end
  end

  assign commit_c = (state_q == SETTLE) && (smp_c == s_q) && (cnt_q == CNT_LAST);

  always_comb begin
    err_new_c  = 1'b0;
    err_kind_c = 2'b00;
    if (commit_c && (en_c != '0)) begin
      if (!onehot_c) begin
        err_new_c  = 1'b1;
        err_kind_c = ERR_BAD_EN;
      end else if (!hit_c) begin
        err_new_c  = 1'b1;
        err_kind_c = ERR_BAD_PAT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      nib_o       <= '0;
      dig_valid_o <= '0;
      upd_o       <= 1'b0;
      upd_idx_o   <= 3'd0;
      err_o       <= 1'b0;
      err_code_o  <= 2'b00;
    end else begin
      s_q   <= smp_c;
      upd_o <= 1'b0;

      case (state_q)
        IDLE: begin
          state_q <= SETTLE;
          cnt_q   <= '0;
        end
        SETTLE: begin
          if (smp_c != s_q) cnt_q <= '0;
          else if (cnt_q == CNT_LAST) state_q <= HELD;
          else cnt_q <= cnt_q + CNT_W'(1);
        end
        HELD: begin
          if (smp_c != s_q) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (commit_c && onehot_c) begin
        upd_o     <= 1'b1;
        upd_idx_o <= idx_c;
      end
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        if (commit_c && onehot_c && en_c[d]) begin
          dig_valid_o[d] <= hit_c;
          if (hit_c) nib_o[4*d +: 4] <= code_c;
        end
      end

      // A new error beats a simultaneous clear and then reports its own code
      if (err_new_c) begin
        err_o <= 1'b1;
        if (!err_o || clr_err_i) err_code_o <= err_kind_c;
      end else if (clr_err_i) begin
        err_o      <= 1'b0;
        err_code_o <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_encoder.sv
// Bench for seg7_capture_encoder: directed scenarios plus random held patterns,
// every cycle compared against a run-length reference model.
module tb_seg7_capture_encoder;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_i;
  logic [ND-1:0] dig_en_i;
  logic          clr_err_i;
  logic [4*ND-1:0] nib_o;
  logic [ND-1:0] dig_valid_o;
  logic          upd_o;
  logic [2:0]    upd_idx_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  seg7_capture_encoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_i       (seg_i),
    .dig_en_i    (dig_en_i),
    .clr_err_i   (clr_err_i),
    .nib_o       (nib_o),
    .dig_valid_o (dig_valid_o),
    .upd_o       (upd_o),
    .upd_idx_o   (upd_idx_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int              run;
  logic [ND+6:0]   last_in;
  logic [4*ND-1:0] m_nib;
  logic [ND-1:0]   m_valid;
  logic            m_upd;
  logic [2:0]      m_idx;
  logic            m_err;
  logic [1:0]      m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern present for STABLE_CYCLES+1 consecutive edges commits once
  task automatic model_edge(input logic r, input logic [6:0] s, input logic [ND-1:0] e, input logic c);
    logic [ND+6:0] cur;
    int ones, hit_i, d_i;
    logic [1:0] nerr;
    if (!r) begin
      run = 0; last_in = '0; m_nib = '0; m_valid = '0; m_upd = 0;
      m_idx = 0; m_err = 0; m_code = 0;
      return;
    end
    cur = {e, s};
    if (run > 0 && cur == last_in) run = (run < SC + 2) ? run + 1 : run;
    else run = 1;
    last_in = cur;
    m_upd = 0;
    nerr = 2'b00;
    if (run == SC + 1 && e != 0) begin
      ones = $countones(e);
      hit_i = -1;
      for (int i = 0; i < 16; i++) if (hex_tab[i] == s) hit_i = i;
      if (ones != 1) nerr = 2'b10;
      else begin
        d_i = 0;
        for (int i = 0; i < ND; i++) if (e[i]) d_i = i;
        m_upd = 1;
        m_idx = 3'(d_i);
        m_valid[d_i] = (hit_i >= 0);
        if (hit_i >= 0) m_nib[4*d_i +: 4] = 4'(hit_i);
        else nerr = 2'b01;
      end
    end
    if (nerr != 0) begin
      if (!m_err || c) m_code = nerr;
      m_err = 1;
    end else if (c) begin
      m_err = 0; m_code = 0;
    end
  endtask

  task automatic step(input logic r, input logic [6:0] s, input logic [ND-1:0] e, input logic c);
    rst_n = r; seg_i = s; dig_en_i = e; clr_err_i = c;
    @(posedge clk);
    model_edge(r, s, e, c);
    #1;
    check("nib", 32'(nib_o), 32'(m_nib));
    check("valid", 32'(dig_valid_o), 32'(m_valid));
    check("upd", 32'(upd_o), 32'(m_upd));
    check("upd_idx", 32'(upd_idx_o), 32'(m_idx));
    check("err", 32'(err_o), 32'(m_err));
    check("err_code", 32'(err_code_o), 32'(m_code));
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] e, input int n);
    repeat (n) step(1'b1, s, e, 1'b0);
  endtask

  initial begin
    logic [6:0] rs;
    logic [ND-1:0] re;
    int r, len;

    step(1'b0, 7'h00, '0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b0);
    check("rst_all", 32'({nib_o, dig_valid_o, upd_o, upd_idx_o, err_o, err_code_o}), 32'd0);

    // 1: digit 0 shows "2"
    hold(7'h5B, 4'b0001, 4);
    check("t1_no_early", 32'(upd_o), 32'd0);
    hold(7'h5B, 4'b0001, 1);
    check("t1_upd", 32'(upd_o), 32'd1);
    check("t1_nib", 32'(nib_o[3:0]), 32'h2);
    check("t1_idx", 32'(upd_idx_o), 32'd0);
    hold(7'h5B, 4'b0001, 1);
    check("t1_pulse", 32'(upd_o), 32'd0);

    // 2: glitch on digit 2 then settle on "3"
    hold(7'h06, 4'b0100, 2);
    hold(7'h4F, 4'b0100, 4);
    check("t2_wait", 32'(upd_o), 32'd0);
    hold(7'h4F, 4'b0100, 1);
    check("t2_nib", 32'(nib_o[11:8]), 32'h3);
    check("t2_idx", 32'(upd_idx_o), 32'd2);

    // 3: invalid pattern on digit 1
    hold(7'h7E, 4'b0010, 5);
    check("t3_upd", 32'(upd_o), 32'd1);
    check("t3_valid1", 32'(dig_valid_o[1]), 32'd0);
    check("t3_nib1", 32'(nib_o[7:4]), 32'h0);
    check("t3_code", 32'({err_o, err_code_o}), 32'b101);
    step(1'b1, 7'h00, 4'b0000, 1'b1);
    check("t3_clr", 32'({err_o, err_code_o}), 32'd0);

    // 4: bad enable, then bad pattern keeps first code, then clear vs. new error
    hold(7'h3F, 4'b0110, 5);
    check("t4_noupd", 32'(upd_o), 32'd0);
    check("t4_code", 32'({err_o, err_code_o}), 32'b110);
    hold(7'h7E, 4'b0001, 5);
    check("t4_first", 32'(err_code_o), 32'b10);
    hold(7'h00, 4'b0001, 4);
    step(1'b1, 7'h00, 4'b0001, 1'b1);
    check("t4_errwins", 32'({err_o, err_code_o}), 32'b101);
    step(1'b1, 7'h00, 4'b0000, 1'b1);

    // 5: every table entry on every digit, then a held blank
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 16; i++) begin
        hold(hex_tab[i], 4'(1 << d), 5);
        check("t5_sweep", 32'(nib_o[4*d +: 4]), 32'(i));
      end
    hold(7'h3F, 4'b0000, 7);
    check("t5_blank", 32'({upd_o, err_o}), 32'd0);

    // 6: reset mid-settle
    hold(7'h66, 4'b1000, 3);
    step(1'b0, 7'h66, 4'b1000, 1'b0);
    check("t6_rst", 32'({nib_o, dig_valid_o, upd_o, err_o}), 32'd0);
    hold(7'h66, 4'b1000, SC);
    check("t6_wait", 32'(upd_o), 32'd0);
    hold(7'h66, 4'b1000, 1);
    check("t6_commit", 32'({upd_o, nib_o[15:12]}), 32'h14);

    // random held patterns
    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      rs = (r < 7) ? hex_tab[$urandom_range(0, 15)] : 7'($urandom);
      r  = $urandom_range(0, 9);
      re = (r < 6) ? ND'(1 << $urandom_range(0, ND - 1)) : (r < 7) ? '0 : ND'($urandom);
      len = $urandom_range(1, 7);
      repeat (len) step($urandom_range(0, 99) != 0, rs, re, $urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
